uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin, frame-locked arbiter that shares the single UART user TX byte interface among `P_NUM_REQ` independent requesters. It sits between the requesters (AXI-Lite register path, DMA, debug console) and the UART top-level TX port. Once a requester is granted, it keeps the UART until the beat flagged `last` is accepted. It optionally prepends a one-byte requester-ID header to every frame.

## Interface
- `P_NUM_REQ`, default 4: number of requesters, 2..8.
- `P_DATA_WIDTH`, default 8: byte width; matches the UART data width.
- `P_HEADER_EN`, default 1: 1 = insert a header byte before each frame; 0 = no header.
- `P_HEADER_BASE`, default 8'hA0: header value is `P_HEADER_BASE + id`, taken modulo 2^`P_DATA_WIDTH`.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high reset.
- `i_req_valid` in `P_NUM_REQ`: per-requester byte valid.
- `i_req_data` in `P_NUM_REQ`*`P_DATA_WIDTH`: requester k occupies bits [k*W +: W].
- `i_req_last` in `P_NUM_REQ`: the current byte is the final byte of the frame.
- `o_req_ready` out `P_NUM_REQ`: per-requester byte accepted (valid & ready).
- `o_user_tx_data` out `P_DATA_WIDTH`: byte to the UART TX.
- `o_user_tx_valid` out 1: byte valid to the UART TX.
- `i_user_tx_ready` in 1: UART TX can accept a byte.
- `o_grant` out `P_NUM_REQ`: one-hot current owner; all-zero when idle.
- `o_busy` out 1: a frame is in progress (state ≠ IDLE).

## Operation
- **Handshake.** A transfer occurs on a rising `clock` edge when valid and ready are both high. This rule applies on both sides.
- **Registered state.**
  - FSM state: IDLE, HEADER, DATA.
  - `r_grant_id`.
  - `r_last_id`: the round-robin pointer.
- **IDLE.**
  - When any `i_req_valid` is high, select the first requester with valid set, searching from `r_last_id+1` upward and wrapping modulo `P_NUM_REQ`.
  - Latch the selection into `r_grant_id`.
  - Next state is HEADER if `P_HEADER_EN`=1, otherwise DATA.
  - If no valid is set, stay in IDLE.
- **HEADER.**
  - `o_user_tx_valid`=1 and `o_user_tx_data`=`P_HEADER_BASE`+`r_grant_id`.
  - All `o_req_ready`=0.
  - When `i_user_tx_ready`=1, go to DATA.
- **DATA.** A combinational pass-through from the granted requester g:
  - `o_user_tx_valid`=`i_req_valid[g]`
  - `o_user_tx_data`=`i_req_data[g]`
  - `o_req_ready[g]`=`i_user_tx_ready`
  - all other ready bits are 0.
- **Leaving DATA.** On a transfer with `i_req_last[g]`=1, set `r_last_id`←g and go to IDLE.
- **Frame lock.**
  - The grant is held through valid gaps; there is no timeout.
  - Other requesters' valid signals are ignored until the owner's frame ends.
- **Requester obligations.** Requesters hold data and last stable while valid is high and ready is low.
- **Idle outputs.** In IDLE: `o_user_tx_valid`=0, `o_user_tx_data`=0, `o_req_ready`=0, `o_grant`=0.
- **Busy and grant flags.** `o_busy`=1 in HEADER and DATA. `o_grant` is the one-hot decode of `r_grant_id` in HEADER and DATA.
- **Simultaneous requests.** The round-robin order guarantees that each of N continuously requesting sources is served once per N frames.
- **Single-byte frame.** A frame whose first byte carries last is legal: the sequence is header, one data byte, then IDLE.
- **Arithmetic.** The pointer increments modulo `P_NUM_REQ`; at `r_last_id`=`P_NUM_REQ`-1 the search starts at 0. The header adds modulo 2^W.

## Timing
- **Reset values.** `reset`=1 forces, asynchronously:
  - state=IDLE, `r_grant_id`=0, `r_last_id`=`P_NUM_REQ`-1 (so requester 0 has first priority);
  - all outputs 0.
- **Reset mid-frame.** Any partial frame is abandoned; no byte is emitted after reset asserts.
- **Arbitration latency.** A valid seen in IDLE at edge n gives a grant and state change at edge n+1.
  - With the header enabled, the header is presented in cycle n+1 and the first data byte is presented no earlier than cycle n+2.
  - With the header disabled, the first data byte is presented in cycle n+1.
- **Throughput.**
  - Within a frame, one byte per cycle when the UART is ready.
  - One IDLE bubble between frames.
  - Per-frame cost: (bytes + `P_HEADER_EN` + 1) cycles minimum.
- **DATA-state paths.** Ready, valid and data are combinational through the block. The HEADER outputs come from registers only.

## Test plan
- **Single requester.** Requester 1 sends a 3-byte frame 11,22,33 with last on 33, with `i_user_tx_ready` tied to 1 and defaults otherwise. Required response: UART sees A1,11,22,33 on consecutive cycles, then `o_busy`=0 one cycle later.
- **Simultaneous start.** All 4 requesters assert valid from reset, each with a 1-byte frame. Required response: frames are emitted in order 0,1,2,3, with headers A0,A1,A2,A3.
- **Fairness and lock.** Requester 0 streams continuously while requester 2 waits. Required response:
  - after requester 0's frame ends, requester 2 is granted next;
  - requester 2's bytes never interleave with requester 0's frame even when requester 0 drops valid for 5 cycles mid-frame.
- **Backpressure.** `i_user_tx_ready` toggles with a 1-of-3 duty during a 4-byte frame. Required response:
  - data and valid are held stable while ready=0;
  - each byte is accepted exactly once;
  - `o_req_ready` pulses exactly 4 times.
- **Reset mid-frame.** Assert `reset` after the 2nd data byte, then release it. Required response:
  - all outputs go to 0 immediately;
  - the next request from requester 3 is granted, and requester 0 wins if it is also pending.
- **Header disabled.** With `P_HEADER_EN`=0 and `P_NUM_REQ`=2, requester 1 sends 2 bytes. Required response: no header byte; first data byte valid one cycle after the request.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing one UART TX byte port among several requesters.
// An optional one-byte requester-ID header is sent ahead of each granted frame.
module uart_tx_arbiter #(
    parameter int          P_NUM_REQ     = 4,
    parameter int          P_DATA_WIDTH  = 8,
    parameter bit          P_HEADER_EN   = 1'b1,
    parameter int unsigned P_HEADER_BASE = 'hA0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [P_NUM_REQ-1:0]              i_req_valid,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]              i_req_last,
    output logic [P_NUM_REQ-1:0]              o_req_ready,
    output logic [P_DATA_WIDTH-1:0]           o_user_tx_data,
    output logic                              o_user_tx_valid,
    input  logic                              i_user_tx_ready,
    output logic [P_NUM_REQ-1:0]              o_grant,
    output logic                              o_busy
);
    localparam int ID_W = $clog2(P_NUM_REQ);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t                  state;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W-1:0]         last_id;
    logic [ID_W-1:0]         pick_id;
    logic                    pick_found;
    int unsigned             idx;
    logic [P_DATA_WIDTH-1:0] hdr_byte;
    logic                    hdr_valid;
    logic [P_NUM_REQ-1:0]    grant_oh;
    logic                    busy;

    // First valid requester strictly after the last owner, wrapping around.
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int i = 1; i <= P_NUM_REQ; i++) begin
            idx = 32'(last_id) + 32'(i);
            if (idx >= 32'(P_NUM_REQ))
                idx = idx - 32'(P_NUM_REQ);
            if (!pick_found && i_req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= '0;
            last_id   <= ID_W'(P_NUM_REQ - 1);
            hdr_byte  <= '0;
            hdr_valid <= 1'b0;
            grant_oh  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        grant_oh <= P_NUM_REQ'(1) << pick_id;
                        busy     <= 1'b1;
                        if (P_HEADER_EN) begin
                            state     <= HEADER;
                            hdr_valid <= 1'b1;
                            hdr_byte  <= P_DATA_WIDTH'(P_HEADER_BASE + 32'(pick_id));
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                HEADER: begin
                    if (i_user_tx_ready) begin
                        state     <= DATA;
                        hdr_valid <= 1'b0;
                        hdr_byte  <= '0;
                    end
                end
                DATA: begin
                    // Grant is held through valid gaps until the last beat is taken.
                    if (i_req_valid[grant_id] && i_user_tx_ready && i_req_last[grant_id]) begin
                        last_id  <= grant_id;
                        state    <= IDLE;
                        grant_oh <= '0;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Header comes straight from registers; data beats pass through combinationally.
    always_comb begin
        o_user_tx_valid = 1'b0;
        o_user_tx_data  = '0;
        o_req_ready     = '0;
        if (hdr_valid) begin
            o_user_tx_valid = 1'b1;
            o_user_tx_data  = hdr_byte;
        end else if (state == DATA) begin
            o_user_tx_valid       = i_req_valid[grant_id];
            o_user_tx_data        = i_req_data[grant_id*P_DATA_WIDTH +: P_DATA_WIDTH];
            o_req_ready[grant_id] = i_user_tx_ready;
        end
    end

    assign o_grant = grant_oh;
    assign o_busy  = busy;

endmodule
